// File: rtl/nios2_jtag_ocimem_sequencer.sv
// rtl/nios2_jtag_ocimem_sequencer.sv - JTAG debug command sequencer for OCI memory word access
module nios2_jtag_ocimem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [1:0] OP_SETADDR = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              unused_jdo;
    assign unused_jdo = ^jdo[35:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            mwdata_q <= '0;
            mon_q    <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mwdata_q <= mwdata_d;
            mon_q    <= mon_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = take_action_ocimem_b ? jdo[31:0] : wdata_q;
        mwdata_d = mwdata_q;
        mon_d    = mon_q;
        ready_d  = ready_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    case (jdo[37:36])
                        OP_SETADDR: begin
                            addr_d  = jdo[ADDR_W-1:0];
                            ready_d = 1'b1;
                            error_d = 1'b0;
                        end
                        OP_READ: begin
                            state_d = RD;
                            ready_d = 1'b0;
                            error_d = 1'b0;
                            cnt_d   = '0;
                        end
                        OP_WRITE: begin
                            state_d  = WR;
                            // wdata_d already folds in a same-cycle _b load
                            mwdata_d = wdata_d;
                            ready_d  = 1'b0;
                            error_d  = 1'b0;
                            cnt_d    = '0;
                        end
                        default: begin
                            ready_d = 1'b1;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            RD, WR: begin
                if (take_action_ocimem_a) begin
                    error_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (state_q == RD) begin
                        mon_d = mem_readdata;
                    end
                    addr_d  = addr_q + ADDR_W'(1);
                    ready_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = mwdata_q;
    assign mem_read      = (state_q == RD);
    assign mem_write     = (state_q == WR);
    assign busy          = (state_q != IDLE);
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_jtag_ocimem_sequencer.sv
// tb/tb_nios2_jtag_ocimem_sequencer.sv - randomized self-checking bench for the OCI memory sequencer
module tb_nios2_jtag_ocimem_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a;
    logic        take_b;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_mon;
    logic        m_ready;
    logic        m_err;

    nios2_jtag_ocimem_sequencer #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .jdo                  (jdo),
        .take_action_ocimem_a (take_a),
        .take_action_ocimem_b (take_b),
        .mem_addr             (mem_addr),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_wdata            (mem_wdata),
        .mem_waitrequest      (mem_waitrequest),
        .mem_readdata         (mem_readdata),
        .MonDReg              (MonDReg),
        .monitor_ready        (monitor_ready),
        .monitor_error        (monitor_error),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        reset_n = 1'b0; take_a = 1'b0; take_b = 1'b0; jdo = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0;
        m_addr = '0; m_wdata = '0; m_mon = '0; m_ready = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({mem_read, mem_write, busy, monitor_ready, monitor_error} !== 5'b0)
            $display("FAIL reset_flags got %b exp 00000", {mem_read, mem_write, busy, monitor_ready, monitor_error});
        else passes++;
        checks++; if (mem_addr !== 8'h00) $display("FAIL reset_addr got %h exp 00", mem_addr); else passes++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", mem_wdata); else passes++;
        checks++; if (MonDReg !== 32'h0) $display("FAIL reset_mondreg got %h exp 0", MonDReg); else passes++;
    endtask

    task automatic check_idle(input string tag);
        checks++; if ({mem_read, mem_write, busy} !== 3'b000)
            $display("FAIL %s_idle rd/wr/busy got %b exp 000", tag, {mem_read, mem_write, busy});
        else passes++;
        checks++; if (monitor_ready !== m_ready || monitor_error !== m_err)
            $display("FAIL %s_status ready/err got %b%b exp %b%b", tag, monitor_ready, monitor_error, m_ready, m_err);
        else passes++;
        checks++; if (mem_addr !== m_addr) $display("FAIL %s_addr got %h exp %h", tag, mem_addr, m_addr); else passes++;
        checks++; if (MonDReg !== m_mon) $display("FAIL %s_mondreg got %h exp %h", tag, MonDReg, m_mon); else passes++;
    endtask

    task automatic do_setaddr(input logic [7:0] a);
        @(negedge clk);
        jdo = {2'b00, 28'($urandom), a};
        take_a = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
        m_addr = a; m_ready = 1'b1; m_err = 1'b0;
        check_idle("setaddr");
    endtask

    task automatic do_load_b(input logic [31:0] d);
        @(negedge clk);
        jdo = {6'($urandom), d};
        take_b = 1'b1;
        @(negedge clk);
        take_b = 1'b0;
        m_wdata = d;
        check_idle("load_b");
    endtask

    task automatic do_illegal();
        @(negedge clk);
        jdo = {2'b11, 36'($urandom)};
        take_a = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
        m_ready = 1'b1; m_err = 1'b1;
        check_idle("illegal");
    endtask

    // Accesses with more than TO-1 stalls abort after exactly TO request cycles.
    task automatic do_access(input logic is_write, input int waits, input logic [31:0] rdata,
                             input logic with_b, input logic [31:0] bdata, input logic inject);
        int          n_req;
        logic [31:0] exp_wd;
        logic [7:0]  a0;
        @(negedge clk);
        jdo = {(is_write ? 2'b10 : 2'b01), 4'h0, (with_b ? bdata : $urandom)};
        take_a = 1'b1;
        take_b = with_b;
        if (with_b) m_wdata = bdata;
        exp_wd = m_wdata;
        a0 = m_addr;
        n_req = (waits >= TO) ? TO : waits + 1;
        @(negedge clk);
        take_a = 1'b0;
        take_b = 1'b0;
        for (int i = 0; i < n_req; i++) begin
            checks++; if ({mem_read, mem_write} !== {~is_write, is_write} || busy !== 1'b1 || monitor_ready !== 1'b0)
                $display("FAIL req_cycle%0d rd/wr/busy/ready got %b%b%b%b exp %b%b10", i,
                         mem_read, mem_write, busy, monitor_ready, ~is_write, is_write);
            else passes++;
            checks++; if (mem_addr !== a0) $display("FAIL req_addr_stable got %h exp %h", mem_addr, a0); else passes++;
            if (is_write) begin
                checks++; if (mem_wdata !== exp_wd) $display("FAIL req_wdata got %h exp %h", mem_wdata, exp_wd); else passes++;
            end
            mem_waitrequest = (i < waits);
            mem_readdata = (i == waits) ? rdata : $urandom;
            if (inject && i == 0) begin
                jdo = {2'($urandom_range(0, 3)), 36'($urandom)};
                take_a = 1'b1;
            end
            @(negedge clk);
            take_a = 1'b0;
        end
        mem_waitrequest = 1'b0;
        if (waits >= TO) begin
            m_err = 1'b1;
        end else begin
            m_addr = m_addr + 8'd1;
            if (!is_write) m_mon = rdata;
            m_err = inject;
        end
        m_ready = 1'b1;
        check_idle(is_write ? "write_done" : "read_done");
    endtask

    task automatic test_first_cycle_setaddr();
        @(negedge clk);
        reset_n = 1'b1;
        jdo = {2'b00, 28'h0, 8'h10};
        take_a = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
        m_addr = 8'h10; m_ready = 1'b1; m_err = 1'b0;
        check_idle("first_cmd");
    endtask

    task automatic test_read_basic();
        do_access(1'b0, 0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        checks++; if (MonDReg !== 32'hDEADBEEF || mem_addr !== 8'h11)
            $display("FAIL read_basic mondreg/addr got %h/%h exp deadbeef/11", MonDReg, mem_addr);
        else passes++;
    endtask

    task automatic test_write_wait();
        do_load_b(32'h12345678);
        do_access(1'b1, 3, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        do_setaddr(8'hFF);
        do_access(1'b1, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (mem_addr !== 8'h00) $display("FAIL wrap_addr got %h exp 00", mem_addr); else passes++;
    endtask

    task automatic test_timeout();
        do_access(1'b0, 20, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_busy_strobe();
        do_access(1'b0, 2, 32'hA5A5_0F0F, 1'b0, 32'h0, 1'b1);
        do_setaddr(8'h42);
    endtask

    task automatic test_same_cycle_b();
        do_load_b(32'h1111_1111);
        do_access(1'b1, 1, 32'h0, 1'b1, 32'h9999_AAAA, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: do_setaddr(8'($urandom));
                1: do_load_b($urandom);
                2: do_illegal();
                3: do_access(1'b1, $urandom_range(0, 5), 32'h0, 1'($urandom_range(0, 1)), $urandom,
                             ($urandom_range(0, 3) == 0));
                default: do_access(1'b0, $urandom_range(0, 5), $urandom, 1'b0, 32'h0,
                                   ($urandom_range(0, 3) == 0));
            endcase
        end
    endtask

    task automatic test_reset_mid_write();
        do_load_b(32'hFEED_BEEF);
        @(negedge clk);
        jdo = {2'b10, 36'h0};
        take_a = 1'b1;
        mem_waitrequest = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
        checks++; if (mem_write !== 1'b1) $display("FAIL mid_write_started got %b exp 1", mem_write); else passes++;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        m_addr = '0; m_wdata = '0; m_mon = '0; m_ready = 1'b0; m_err = 1'b0;
        checks++; if (mem_write !== 1'b0) $display("FAIL reset_mid mem_write got %b exp 0", mem_write); else passes++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mid wdata got %h exp 0", mem_wdata); else passes++;
        check_idle("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_first_cycle_setaddr();
        test_read_basic();
        test_write_wait();
        test_wrap();
        test_timeout();
        test_busy_strobe();
        do_illegal();
        do_setaddr(8'h20);
        test_same_cycle_b();
        test_random();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/nios2_jtag_ocimem_sequencer.md
NIOS2_JTAG_OCIMEM_SEQUENCER -- requirements
Module: nios2_jtag_ocimem_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: OCI memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: max waitrequest cycles before abort, 1..255.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port jdo, input, 38: debug command/data word from the JTAG sysclk domain.
REQ-006 SHALL have port take_action_ocimem_a, input, 1: one-cycle command strobe.
REQ-007 SHALL have port take_action_ocimem_b, input, 1: one-cycle write-data load strobe.
REQ-008 SHALL have port mem_addr, output, ADDR_W: word address to OCI memory.
REQ-009 SHALL have port mem_read / mem_write, output, 1 each: access requests.
REQ-010 SHALL have port mem_wdata, output, 32: write data.
REQ-011 SHALL have port mem_waitrequest, input, 1: high = access not yet accepted.
REQ-012 SHALL have port mem_readdata, input, 32: valid in the cycle a read is accepted.
REQ-013 SHALL have port MonDReg, output, 32: read-back data to the debug TCK chain.
REQ-014 SHALL have ports monitor_ready / monitor_error / busy, output, 1 each: status.

Function
REQ-015 SHALL decode jdo[37:36] on take_action_ocimem_a: 00 SETADDR, 01 READ, 10 WRITE, 11 illegal.
REQ-016 SETADDR SHALL load addr <= jdo[ADDR_W-1:0] next cycle, set monitor_ready=1, no memory access.
REQ-017 take_action_ocimem_b SHALL load wdata reg <= jdo[31:0] whenever asserted, busy or not.
REQ-018 SHALL implement FSM IDLE, RD, WR; busy=1 iff state != IDLE.
REQ-019 READ in IDLE: next cycle state RD, mem_read=1, monitor_ready=0, monitor_error=0.
REQ-020 WRITE in IDLE: next cycle state WR, mem_write=1, mem_wdata=wdata reg, monitor_ready=0, monitor_error=0.
REQ-021 If _a (WRITE) and _b assert in the same cycle, the write SHALL use that cycle's jdo[31:0].
REQ-022 mem_read/mem_write SHALL stay high, address/data stable, until a cycle with mem_waitrequest=0.
REQ-023 On accepted read, SHALL capture MonDReg <= mem_readdata in that cycle's edge.
REQ-024 On any accept, SHALL drop the request next cycle, return to IDLE, set monitor_ready=1, addr <= addr+1.
REQ-025 Address increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-026 SHALL count consecutive waitrequest-high cycles in RD/WR; at count==TIMEOUT, SHALL drop request, return to IDLE, set monitor_ready=1, monitor_error=1, leave addr and MonDReg unchanged.
REQ-027 Illegal opcode in IDLE SHALL set monitor_error=1, monitor_ready=1, no access.
REQ-028 take_action_ocimem_a while busy SHALL be ignored except monitor_error <= 1, reported when the op completes.
REQ-029 monitor_error SHALL clear only on acceptance of a legal command in IDLE.
REQ-030 Minimum latency: command strobe to monitor_ready=1 SHALL be 2 cycles with waitrequest low.
REQ-031 mem_read and mem_write SHALL never be high together.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, MonDReg=0, monitor_ready=0, monitor_error=0, busy=0, timeout count=0.
REQ-033 Reset mid-access SHALL abandon the access with no completion indication after release.
REQ-034 First command SHALL be accepted in the first cycle after reset_n deasserts.

Verification
REQ-035 SETADDR 0x10, READ with waitrequest low, readdata 0xDEADBEEF -> MonDReg=0xDEADBEEF, mem_addr=0x11, ready=1, error=0.
REQ-036 _b jdo=0x12345678, WRITE, waitrequest high 3 cycles -> mem_write held 4 cycles at stable addr/data, then ready=1.
REQ-037 SETADDR 0xFF, WRITE accepted -> mem_addr wraps to 0x00.
REQ-038 READ with waitrequest stuck high, TIMEOUT=4 -> request dropped after 4 wait cycles, ready=1, error=1, MonDReg unchanged.
REQ-039 Second READ strobe during busy RD -> ignored, error=1 at completion; next legal command clears error.
REQ-040 reset_n low during WR -> mem_write=0 immediately, all outputs at reset values.
